// File: rtl/lr_stub_sum_accumulator.sv
// lr_stub_sum_accumulator
// Accumulates one signed product per stub over a track and publishes the
// per-track sum, saturating stub count and overflow flag through a single
// registered output slot with a valid/ready handshake.
// The accumulator is idle when cnt == 0 and running otherwise; the output
// slot is full when dout_valid is set.
module lr_stub_sum_accumulator #(
   parameter int DIN_WIDTH = 33,
   parameter int ACC_WIDTH = 40,
   parameter int CNT_WIDTH = 4
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst_n,
   input  logic signed [DIN_WIDTH-1:0] din,
   input  logic                        din_valid,
   input  logic                        din_last,
   output logic                        din_ready,
   output logic signed [ACC_WIDTH-1:0] dout_sum,
   output logic        [CNT_WIDTH-1:0] dout_count,
   output logic                        dout_ovf,
   output logic                        dout_valid,
   input  logic                        dout_ready
);

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] din_ext;
   logic signed [ACC_WIDTH-1:0] sum_next;
   logic        [CNT_WIDTH-1:0] cnt;
   logic        [CNT_WIDTH-1:0] cnt_next;
   logic                        ovf;
   logic                        add_ovf;
   logic                        accept;
   logic                        accept_last;
   logic                        transfer;

   // A full slot that is not being drained stalls the whole input stream,
   // so the accumulator never runs ahead of the result it has to publish.
   assign din_ready   = !(dout_valid && !dout_ready);
   assign accept      = din_valid && din_ready;
   assign accept_last = accept && din_last;
   assign transfer    = dout_valid && dout_ready;

   // Next-sum arithmetic: sign-extend, wrap-around add, signed overflow, saturating count.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      din_ext  = '0;
      sum_next = '0;
      add_ovf  = 1'b0;
      cnt_next = cnt;

      din_ext  = ACC_WIDTH'(din);
      sum_next = acc + din_ext;
      add_ovf  = (acc[ACC_WIDTH-1] == din_ext[ACC_WIDTH-1]) &&
                 (sum_next[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
      cnt_next = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
   end

   // Running accumulator: add on non-last beats, clear once a track is handed off.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (accept_last) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (accept) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         acc <= sum_next;
         cnt <= cnt_next;
         ovf <= ovf | add_ovf;
      end
   end

   // Output slot: load on the last beat (even while draining), otherwise empty on transfer.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         dout_sum   <= '0;
         dout_count <= '0;
         dout_ovf   <= 1'b0;
         dout_valid <= 1'b0;
      end else if (accept_last) begin
         dout_sum   <= sum_next;
         dout_count <= cnt_next;
         dout_ovf   <= ovf | add_ovf;
         dout_valid <= 1'b1;
      end else if (transfer) begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lr_stub_sum_accumulator.sv
// Directed and randomised checks for lr_stub_sum_accumulator.
module tb_lr_stub_sum_accumulator;

   localparam int DW = 33;
   localparam int AW = 40;
   localparam int CW = 4;
   localparam int N_TRACKS = 1000;

   logic                 ap_clk;
   logic                 ap_rst_n;
   logic signed [DW-1:0] din;
   logic                 din_valid;
   logic                 din_last;
   logic                 din_ready;
   logic signed [AW-1:0] dout_sum;
   logic        [CW-1:0] dout_count;
   logic                 dout_ovf;
   logic                 dout_valid;
   logic                 dout_ready;

   int n_checks = 0;
   int n_errors = 0;

   lr_stub_sum_accumulator #(
      .DIN_WIDTH(DW),
      .ACC_WIDTH(AW),
      .CNT_WIDTH(CW)
   ) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .din       (din),
      .din_valid (din_valid),
      .din_last  (din_last),
      .din_ready (din_ready),
      .dout_sum  (dout_sum),
      .dout_count(dout_count),
      .dout_ovf  (dout_ovf),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Present one beat from posedge+1 and hold it until accepted; return at posedge+1.
   task automatic drive_beat(input logic signed [DW-1:0] d, input logic last);
      int waited;
      waited = 0;
      din       = d;
      din_last  = last;
      din_valid = 1'b1;
      @(negedge ap_clk);
      while (!din_ready && waited < 200) begin
         @(negedge ap_clk);
         waited++;
      end
      if (!din_ready) check("beat_accept_timeout", 0, 1);
      @(posedge ap_clk);
      #1;
      din_valid = 1'b0;
      din_last  = 1'b0;
   endtask

   task automatic apply_reset();
      ap_rst_n  = 1'b0;
      din_valid = 1'b0;
      din_last  = 1'b0;
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
   endtask

   // Reference model for the random stress.
   logic signed [DW-1:0] beat_din[$];
   logic                 beat_last[$];
   logic signed [AW-1:0] exp_sum[$];
   logic        [CW-1:0] exp_cnt[$];
   logic                 exp_ovf[$];

   task automatic build_stress();
      logic signed [AW-1:0] m_acc, m_ext, m_sum;
      logic        [CW-1:0] m_cnt;
      logic                 m_ovf;
      logic signed [DW-1:0] d;
      int                   len;
      for (int t = 0; t < N_TRACKS; t++) begin
         len   = $urandom_range(8, 1);
         m_acc = '0;
         m_cnt = '0;
         m_ovf = 1'b0;
         for (int b = 0; b < len; b++) begin
            d     = {1'($urandom), 32'($urandom)};
            m_ext = AW'(d);
            m_sum = m_acc + m_ext;
            if (m_acc[AW-1] == m_ext[AW-1] && m_sum[AW-1] != m_acc[AW-1]) m_ovf = 1'b1;
            if (m_cnt != 4'hf) m_cnt = m_cnt + 4'd1;
            m_acc = m_sum;
            beat_din.push_back(d);
            beat_last.push_back(b == len - 1);
         end
         exp_sum.push_back(m_acc);
         exp_cnt.push_back(m_cnt);
         exp_ovf.push_back(m_ovf);
      end
   endtask

   initial begin
      int bi, got, cyc;
      ap_rst_n   = 1'b0;
      din        = '0;
      din_valid  = 1'b0;
      din_last   = 1'b0;
      dout_ready = 1'b1;
      apply_reset();

      // Reset state
      check("rst_dout_valid", dout_valid, 0);
      check("rst_din_ready", din_ready, 1);
      check("rst_dout_sum", dout_sum, 0);
      check("rst_dout_count", dout_count, 0);
      check("rst_dout_ovf", dout_ovf, 0);

      // Three-stub track 100, -30, 5
      drive_beat(100, 1'b0);
      drive_beat(-30, 1'b0);
      drive_beat(5, 1'b1);
      check("t1_valid", dout_valid, 1);
      check("t1_sum", dout_sum, 75);
      check("t1_count", dout_count, 3);
      check("t1_ovf", dout_ovf, 0);
      @(posedge ap_clk); #1;
      check("t1_valid_drop", dout_valid, 0);
      check("t1_sum_hold", dout_sum, 75);

      // Single-stub track -(2^32)
      drive_beat(-33'sd4294967296, 1'b1);
      check("t2_valid", dout_valid, 1);
      check("t2_sum", dout_sum, -64'sd4294967296);
      check("t2_count", dout_count, 1);
      check("t2_ovf", dout_ovf, 0);
      @(posedge ap_clk); #1;

      // Back-pressure: A=3+4 held, B beats stalled, then A drains as B loads
      dout_ready = 1'b0;
      drive_beat(3, 1'b0);
      drive_beat(4, 1'b1);
      check("t3_a_valid", dout_valid, 1);
      check("t3_stall_ready", din_ready, 0);
      din = 20; din_last = 1'b0; din_valid = 1'b1;
      repeat (3) begin
         @(posedge ap_clk); #1;
      end
      check("t3_hold_sum", dout_sum, 7);
      check("t3_hold_count", dout_count, 2);
      check("t3_hold_valid", dout_valid, 1);
      check("t3_hold_ready", din_ready, 0);
      din = -12; din_last = 1'b1;
      @(posedge ap_clk); #1;
      check("t3_hold_sum2", dout_sum, 7);
      dout_ready = 1'b1;
      #1;
      check("t3_release_ready", din_ready, 1);
      @(posedge ap_clk); #1;
      dout_ready = 1'b0; din_valid = 1'b0; din_last = 1'b0;
      check("t3_b2b_valid", dout_valid, 1);
      check("t3_b_sum", dout_sum, -12);
      check("t3_b_count", dout_count, 1);
      dout_ready = 1'b1;
      @(posedge ap_clk); #1;
      check("t3_drain", dout_valid, 0);

      // 20 stubs of 2^32-1: count saturates, no overflow yet
      for (int i = 0; i < 20; i++) drive_beat(33'sd4294967295, i == 19);
      check("t4_count_sat", dout_count, 15);
      check("t4_sum", dout_sum, 64'sd85899345900);
      check("t4_ovf", dout_ovf, 0);
      // 130 stubs of 2^32-1: crosses 2^39-1 on stub 129 and wraps
      for (int i = 0; i < 130; i++) drive_beat(33'sd4294967295, i == 129);
      check("t4b_count_sat", dout_count, 15);
      check("t4b_sum_wrap", dout_sum, -64'sd541165879426);
      check("t4b_ovf", dout_ovf, 1);
      drive_beat(1, 1'b1);
      check("t4c_ovf_clear", dout_ovf, 0);
      check("t4c_count", dout_count, 1);
      check("t4c_sum", dout_sum, 1);
      @(posedge ap_clk); #1;

      // Async reset with a pending result
      dout_ready = 1'b0;
      drive_beat(33, 1'b1);
      #2 ap_rst_n = 1'b0;
      #1;
      check("t5_rst_pending_valid", dout_valid, 0);
      check("t5_rst_pending_sum", dout_sum, 0);
      dout_ready = 1'b1;
      apply_reset();

      // Async reset mid-track, then a fresh one-beat track
      drive_beat(50, 1'b0);
      drive_beat(60, 1'b0);
      #2 ap_rst_n = 1'b0;
      #1;
      check("t5_rst_ready", din_ready, 1);
      apply_reset();
      drive_beat(9, 1'b1);
      check("t5_sum", dout_sum, 9);
      check("t5_count", dout_count, 1);
      check("t5_ovf", dout_ovf, 0);
      @(posedge ap_clk); #1;

      // Random valid/ready stress against the model
      apply_reset();
      build_stress();
      bi = 0; got = 0; cyc = 0;
      while (got < N_TRACKS && cyc < 60000) begin
         @(posedge ap_clk); #1;
         dout_ready = ($urandom_range(99) < 70);
         if (bi < beat_din.size()) begin
            din_valid = ($urandom_range(99) < 75);
            din       = beat_din[bi];
            din_last  = beat_last[bi];
         end else begin
            din_valid = 1'b0;
            din_last  = 1'b0;
         end
         @(negedge ap_clk);
         if (dout_valid && dout_ready) begin
            check("stress_sum", dout_sum, exp_sum[got]);
            check("stress_count", dout_count, exp_cnt[got]);
            check("stress_ovf", dout_ovf, exp_ovf[got]);
            got++;
         end
         if (din_valid && din_ready) bi++;
         cyc++;
      end
      check("stress_tracks", got, N_TRACKS);
      check("stress_beats", bi, beat_din.size());
      din_valid = 1'b0;
      @(posedge ap_clk); #1;
      dout_ready = 1'b1;
      @(posedge ap_clk); #1;
      check("stress_no_extra", dout_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
